// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the decoded-instruction record and the sizing
// used by the circular queues between decode and dispatch.
package rv32i_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
    } instruction_info_reg_t;

    localparam int IQ_DEPTH = 16;
    localparam int IQ_PTR_W = $clog2(IQ_DEPTH) + 1;

    // Index bits plus one wrap bit, same shape as the ROB and free-list pointers.
    typedef logic [IQ_PTR_W-1:0] iq_ptr_t;

endpackage

// File: rtl/instruction_queue.sv
// Circular FIFO of decoded instructions between decode and rename/dispatch.
// Wrap-bit pointers give full/empty/count; flush empties the queue in one edge.
module instruction_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enq_valid,
    input  instruction_info_reg_t enq_data,
    output logic                  enq_ready,
    output logic                  deq_valid,
    output instruction_info_reg_t deq_data,
    input  logic                  deq_ready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    instruction_info_reg_t mem [DEPTH];

    logic [CNT_W-1:0] head_ptr;
    logic [CNT_W-1:0] tail_ptr;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             enq_fire;
    logic             deq_fire;

    assign head_idx = head_ptr[IDX_W-1:0];
    assign tail_idx = tail_ptr[IDX_W-1:0];

    assign empty     = (head_ptr == tail_ptr);
    assign full      = (head_idx == tail_idx) && (head_ptr[CNT_W-1] != tail_ptr[CNT_W-1]);
    assign count     = tail_ptr - head_ptr;
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_data  = mem[head_idx];

    assign enq_fire = enq_valid && enq_ready;
    assign deq_fire = deq_valid && deq_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (enq_fire) tail_ptr <= tail_ptr + PTR_ONE;
            if (deq_fire) head_ptr <= head_ptr + PTR_ONE;
        end
    end

    // A flushed enqueue is dropped entirely, so storage is left untouched too.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) mem[tail_idx] <= enq_data;
    end

`ifndef SYNTHESIS
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
        count <= DEPTH_CNT);

    a_ptr_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (!flush && !enq_fire && !deq_fire) |=>
            (head_ptr == $past(head_ptr)) && (tail_ptr == $past(tail_ptr)));
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// Directed bench for instruction_queue: a vector table for basic ordering and
// empty-side corners, then hand sequences for full, streaming, flush and reset.
module tb_instruction_queue;
    import rv32i_types::*;

    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  enq_valid = 1'b0;
    instruction_info_reg_t enq_data;
    logic                  enq_ready;
    logic                  deq_valid;
    instruction_info_reg_t deq_data;
    logic                  deq_ready = 1'b0;
    logic                  flush = 1'b0;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;

    int total = 0;
    int bad   = 0;

    instruction_queue #(.DEPTH(IQ_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] inst;
        logic        dr;
        int          cnt;
        logic        dv;
        logic [31:0] head;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] inst, input logic dr, input logic fl);
        enq_valid     = ev;
        enq_data      = '0;
        enq_data.inst = inst;
        enq_data.pc   = inst ^ 32'h8000_0000;
        deq_ready     = dr;
        flush         = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int cnt);
        chk({tag, " count"}, 32'(count), 32'(cnt));
        chk({tag, " empty"}, 32'(empty), 32'(cnt == 0));
        chk({tag, " full"}, 32'(full), 32'(cnt == IQ_DEPTH));
        chk({tag, " enq_ready"}, 32'(enq_ready), 32'(cnt != IQ_DEPTH));
        chk({tag, " deq_valid"}, 32'(deq_valid), 32'(cnt != 0));
    endtask

    initial begin
        // Each row: outputs checked before the edge, then inputs applied for that edge.
        vecs[0]  = '{1'b1, 32'h0000_0013, 1'b0, 0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0010_0093, 1'b0, 1, 1'b1, 32'h0000_0013};
        vecs[2]  = '{1'b1, 32'h0020_0113, 1'b0, 2, 1'b1, 32'h0000_0013};
        vecs[3]  = '{1'b1, 32'h0030_0193, 1'b0, 3, 1'b1, 32'h0000_0013};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 4, 1'b1, 32'h0000_0013};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 3, 1'b1, 32'h0010_0093};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 2, 1'b1, 32'h0020_0113};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 32'h0030_0193};
        vecs[8]  = '{1'b1, 32'h0040_0213, 1'b1, 0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 32'h0040_0213};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h0};

        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step();
        chk_state("reset", 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            chk_state($sformatf("vec%0d", i), vecs[i].cnt);
            if (vecs[i].dv) chk($sformatf("vec%0d head", i), deq_data.inst, vecs[i].head);
            drive(vecs[i].ev, vecs[i].inst, vecs[i].dr, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("table end", 0);

        // Full: the 17th enqueue is refused even though a dequeue fires.
        for (int i = 0; i < IQ_DEPTH; i++) begin
            drive(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("filled", IQ_DEPTH);
        chk("filled head", deq_data.inst, 32'h1000);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("full enq_ready with deq_ready", 32'(enq_ready), 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("after full deq", IQ_DEPTH - 1);
        for (int i = 1; i < IQ_DEPTH; i++) begin
            chk($sformatf("drain %0d", i), deq_data.inst, 32'h1000 + 32'(i));
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("drained", 0);

        // Streaming at count 3 for 40 cycles, across two pointer wraps.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stream%0d count", i), 32'(count), 32'd3);
            chk($sformatf("stream%0d head", i), deq_data.inst, 32'h2000 + 32'(i));
            drive(1'b1, 32'h2003 + 32'(i), 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream tail %0d", i), deq_data.inst, 32'h2028 + 32'(i));
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("stream end", 0);

        // Flush at count 7 overrides a simultaneous enqueue and dequeue.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("pre flush", 7);
        drive(1'b1, 32'hBAD0, 1'b1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("post flush", 0);
        step();
        chk_state("post flush idle", 0);
        drive(1'b1, 32'h3100, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("after flush enq", 1);
        chk("after flush head", deq_data.inst, 32'h3100);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("after flush drain", 0);

        // Asynchronous reset between edges with count 9.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_state("pre reset", 9);
        #2 rst_n = 1'b0;
        #1;
        chk_state("async reset", 0);
        #1 rst_n = 1'b1;
        step();
        chk_state("post reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
